// File: rtl/mux_bus_target.sv
// mux_bus_target: target on a multiplexed address/data bus.
// An ale pulse latches the address and space (memory or IO). A read or write
// strobe then runs the access, optionally after WAIT_STATES wait cycles.
// Read data, drive enable, ready and a sticky error flag are all registered.
//
// Bus handshake: an access is requested by holding exactly one strobe low after
// an address phase; rdy high means the data phase is complete (read data valid
// on ad_out with ad_oe high, or the write has been committed). The access ends
// on the first edge where both strobes are sampled high. A new ale always wins
// and aborts whatever is pending.
module mux_bus_target #(
   parameter int          DW          = 16,
   parameter int          AW          = 20,
   parameter int          MEM_AW      = 10,
   parameter int          WAIT_STATES = 0,
   parameter logic [15:0] ID          = 16'hB16E
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [DW-1:0]    ad_lo_in,
   input  logic [AW-DW-1:0] ad_hi_in,
   input  logic             ale,
   input  logic             pio,
   input  logic             oe_n,
   input  logic             we_n,
   output logic [DW-1:0]    ad_out,
   output logic             ad_oe,
   output logic             rdy,
   output logic             err,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADDR   = 2'd1,
      S_WAIT   = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            space_q, space_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [DW-1:0]   ad_out_q, ad_out_d;
   logic            ad_oe_q, ad_oe_d;
   logic            rdy_q, rdy_d;
   logic            err_q, err_d;
   logic [DW-1:0]   scratch_q, scratch_d;
   logic [DW-1:0]   cyc_q, cyc_d;

   logic [DW-1:0]   mem [2**MEM_AW];

   logic            strobe_both;
   logic            strobe_none;
   logic            enter_active;
   logic            err_set;
   logic            err_clr;
   logic            mem_we;
   logic            mem_hi_nz;
   logic            io_hi_nz;
   logic [MEM_AW-1:0] mem_idx;
   logic [DW-1:0]   rd_data;
   logic            rd_err;

   assign strobe_both = !oe_n && !we_n;
   assign strobe_none = oe_n && we_n;
   assign mem_hi_nz   = |addr_q[AW-1:MEM_AW];
   assign io_hi_nz    = |addr_q[AW-1:2];
   assign mem_idx     = addr_q[MEM_AW-1:0];

   // Read data for the latched address: memory, IO registers, or fill values.
   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (!space_q) begin
         if (mem_hi_nz) begin
            rd_data = '1;
            rd_err  = 1'b1;
         end else begin
            rd_data = mem[mem_idx];
         end
      end else if (!io_hi_nz) begin
         case (addr_q[1:0])
            2'd0:    rd_data = scratch_q;
            2'd1:    rd_data = {{(DW-1){1'b0}}, err_q};
            2'd2:    rd_data = cyc_q;
            default: rd_data = DW'(ID);
         endcase
      end
   end

   // Next-state and output logic; ale takes priority over every state.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      space_d      = space_q;
      wcnt_d       = wcnt_q;
      ad_out_d     = ad_out_q;
      ad_oe_d      = ad_oe_q;
      rdy_d        = rdy_q;
      scratch_d    = scratch_q;
      cyc_d        = cyc_q;
      err_set      = 1'b0;
      err_clr      = 1'b0;
      mem_we       = 1'b0;
      enter_active = 1'b0;

      if (ale) begin
         addr_d  = {ad_hi_in, ad_lo_in};
         space_d = pio;
         wcnt_d  = 4'(WAIT_STATES);
         state_d = S_ADDR;
         ad_oe_d = 1'b0;
         rdy_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: begin
               if (strobe_both) begin
                  err_set = 1'b1;
                  state_d = S_IDLE;
               end else if (!strobe_none) begin
                  if (WAIT_STATES == 0) enter_active = 1'b1;
                  else                  state_d      = S_WAIT;
               end
            end
            S_WAIT: begin
               if (strobe_both) begin
                  err_set = 1'b1;
                  state_d = S_IDLE;
               end else if (strobe_none) begin
                  state_d = S_IDLE;
               end else begin
                  // The edge that takes the counter to zero is the entry edge.
                  if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
                  if (wcnt_q <= 4'd1) enter_active = 1'b1;
               end
            end
            S_ACTIVE: begin
               if (strobe_both) begin
                  err_set = 1'b1;
                  state_d = S_IDLE;
                  ad_oe_d = 1'b0;
                  rdy_d   = 1'b0;
               end else if (strobe_none) begin
                  state_d = S_IDLE;
                  ad_oe_d = 1'b0;
                  rdy_d   = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // One-shot actions on the edge that enters ACTIVE.
      if (enter_active) begin
         state_d = S_ACTIVE;
         rdy_d   = 1'b1;
         cyc_d   = cyc_q + 1'b1;
         if (!oe_n) begin
            ad_out_d = rd_data;
            ad_oe_d  = 1'b1;
            if (rd_err) err_set = 1'b1;
         end else if (!space_q) begin
            if (mem_hi_nz) err_set = 1'b1;
            else           mem_we  = 1'b1;
         end else if (!io_hi_nz) begin
            case (addr_q[1:0])
               2'd0:    scratch_d = ad_lo_in;
               2'd1:    err_clr   = ad_lo_in[0];
               default: ;
            endcase
         end
      end

      // A new error outranks a status clear on the same edge.
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (err_set) err_d = 1'b1;
   end

   // Control and IO register state with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         space_q   <= 1'b0;
         wcnt_q    <= '0;
         ad_out_q  <= '0;
         ad_oe_q   <= 1'b0;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
         scratch_q <= '0;
         cyc_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         space_q   <= space_d;
         wcnt_q    <= wcnt_d;
         ad_out_q  <= ad_out_d;
         ad_oe_q   <= ad_oe_d;
         rdy_q     <= rdy_d;
         err_q     <= err_d;
         scratch_q <= scratch_d;
         cyc_q     <= cyc_d;
      end
   end

   // Memory array: never cleared; a write coinciding with reset is dropped.
   always_ff @(posedge CLK) begin
      if (nRST && mem_we) mem[mem_idx] <= ad_lo_in;
   end

   assign ad_out      = ad_out_q;
   assign ad_oe       = ad_oe_q;
   assign rdy         = rdy_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_bus_target.sv
// Directed bench for mux_bus_target: one instance with no wait states and one
// with three, sharing the same bus inputs.
module tb_mux_bus_target;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ADDR   = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_ACTIVE = 2'd3;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [15:0] ad_lo = '0;
   logic [3:0]  ad_hi = '0;
   logic        ale = 1'b0;
   logic        pio = 1'b0;
   logic        oe_n = 1'b1;
   logic        we_n = 1'b1;

   logic [15:0] ad_out0, ad_out1;
   logic        ad_oe0, ad_oe1, rdy0, rdy1, err0, err1;
   logic [1:0]  st0, st1;

   int n_vec  = 0;
   int n_miss = 0;

   // clock / reset
   always #5 clk = ~clk;

   mux_bus_target #(.WAIT_STATES(0)) u_dut0 (
      .CLK(clk), .nRST(n_rst), .ad_lo_in(ad_lo), .ad_hi_in(ad_hi), .ale(ale),
      .pio(pio), .oe_n(oe_n), .we_n(we_n), .ad_out(ad_out0), .ad_oe(ad_oe0),
      .rdy(rdy0), .err(err0), .dbg_state_o(st0)
   );

   mux_bus_target #(.WAIT_STATES(3)) u_dut1 (
      .CLK(clk), .nRST(n_rst), .ad_lo_in(ad_lo), .ad_hi_in(ad_hi), .ale(ale),
      .pio(pio), .oe_n(oe_n), .we_n(we_n), .ad_out(ad_out1), .ad_oe(ad_oe1),
      .rdy(rdy1), .err(err1), .dbg_state_o(st1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst = 1'b0; ale = 1'b0; oe_n = 1'b1; we_n = 1'b1;
      tick(); tick();
      n_rst = 1'b1;
   endtask

   task automatic addr_phase(input logic [19:0] a, input logic sp);
      ale = 1'b1; pio = sp; ad_hi = a[19:16]; ad_lo = a[15:0];
      tick();
      ale = 1'b0;
   endtask

   // Zero-wait write on instance 0.
   task automatic wr0(input logic [19:0] a, input logic sp, input logic [15:0] d, input string tag);
      addr_phase(a, sp);
      we_n = 1'b0; ad_lo = d;
      tick();
      check({tag, " wr rdy"}, rdy0, 1);
      check({tag, " wr oe"}, ad_oe0, 0);
      we_n = 1'b1;
      tick();
      check({tag, " wr rdy off"}, rdy0, 0);
   endtask

   // Zero-wait read on instance 0.
   task automatic rd0(input logic [19:0] a, input logic sp, input logic [15:0] exp, input string tag);
      addr_phase(a, sp);
      oe_n = 1'b0;
      tick();
      check({tag, " rd data"}, ad_out0, exp);
      check({tag, " rd oe"}, ad_oe0, 1);
      check({tag, " rd rdy"}, rdy0, 1);
      oe_n = 1'b1;
      tick();
      check({tag, " rd oe off"}, ad_oe0, 0);
      check({tag, " rd rdy off"}, rdy0, 0);
   endtask

   // Three-wait read on instance 1.
   task automatic rd1(input logic [19:0] a, input logic [15:0] exp, input string tag);
      addr_phase(a, 1'b0);
      oe_n = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check({tag, " ws rdy low"}, rdy1, 0);
         check({tag, " ws oe low"}, ad_oe1, 0);
      end
      tick();
      check({tag, " ws rdy"}, rdy1, 1);
      check({tag, " ws oe"}, ad_oe1, 1);
      check({tag, " ws data"}, ad_out1, exp);
      oe_n = 1'b1;
      tick();
      check({tag, " ws rdy off"}, rdy1, 0);
      check({tag, " ws oe off"}, ad_oe1, 0);
   endtask

   initial begin
      // reset state
      do_reset();
      check("rst ad_out", ad_out0, 16'h0000);
      check("rst ad_oe", ad_oe0, 0);
      check("rst rdy", rdy0, 0);
      check("rst err", err0, 0);
      check("rst state", st0, S_IDLE);
      check("rst ad_oe ws", ad_oe1, 0);

      // basic write then read back
      wr0(20'h00010, 1'b0, 16'hA5A5, "mem10");
      rd0(20'h00010, 1'b0, 16'hA5A5, "mem10");

      // address phase holds while strobes idle
      addr_phase(20'h00010, 1'b0);
      tick(); tick();
      check("addr hold state", st0, S_ADDR);
      check("addr hold rdy", rdy0, 0);

      // top word of memory, and earlier word intact
      wr0(20'h003FF, 1'b0, 16'h1234, "memtop");
      rd0(20'h003FF, 1'b0, 16'h1234, "memtop");
      rd0(20'h00010, 1'b0, 16'hA5A5, "mem10b");

      // out-of-range memory read, then clear via status
      addr_phase(20'h10000, 1'b0);
      oe_n = 1'b0;
      tick();
      check("oor rd data", ad_out0, 16'hFFFF);
      check("oor rd err", err0, 1);
      oe_n = 1'b1;
      tick();
      wr0(20'h00001, 1'b1, 16'h0001, "clr");
      check("clr err", err0, 0);

      // out-of-range write ignored and flagged; no aliasing onto word 0
      wr0(20'h00000, 1'b0, 16'h1111, "mem0");
      wr0(20'h00400, 1'b0, 16'h5555, "oorwr");
      check("oor wr err", err0, 1);
      rd0(20'h00000, 1'b0, 16'h1111, "mem0");
      rd0(20'h00001, 1'b1, 16'h0001, "status");
      wr0(20'h00001, 1'b1, 16'h0000, "clr0");
      check("clr0 keeps err", err0, 1);
      wr0(20'h00001, 1'b1, 16'h0001, "clr1");
      check("clr1 err", err0, 0);

      // IO registers
      wr0(20'h00000, 1'b1, 16'hBEEF, "scr");
      rd0(20'h00000, 1'b1, 16'hBEEF, "scr");
      rd0(20'h00003, 1'b1, 16'hB16E, "id");
      wr0(20'h00004, 1'b1, 16'h7777, "iohi");
      check("iohi err", err0, 0);
      rd0(20'h00004, 1'b1, 16'h0000, "iohi");
      rd0(20'h00000, 1'b1, 16'hBEEF, "scr2");

      // both strobes low: error, no drive, no write
      addr_phase(20'h00010, 1'b0);
      oe_n = 1'b0; we_n = 1'b0; ad_lo = 16'h0BAD;
      tick();
      check("both oe", ad_oe0, 0);
      check("both err", err0, 1);
      check("both state", st0, S_IDLE);
      check("both rdy", rdy0, 0);
      oe_n = 1'b1; we_n = 1'b1;
      tick();
      rd0(20'h00010, 1'b0, 16'hA5A5, "both mem");
      wr0(20'h00001, 1'b1, 16'h0001, "clr2");
      check("clr2 err", err0, 0);

      // reset during an active read
      addr_phase(20'h00010, 1'b0);
      oe_n = 1'b0;
      tick();
      check("pre rst oe", ad_oe0, 1);
      n_rst = 1'b0;
      tick();
      check("mid rst oe", ad_oe0, 0);
      check("mid rst rdy", rdy0, 0);
      check("mid rst state", st0, S_IDLE);
      n_rst = 1'b1; oe_n = 1'b1;
      tick();
      rd0(20'h00010, 1'b0, 16'hA5A5, "post rst");
      rd0(20'h00000, 1'b1, 16'h0000, "scr rst");

      // write pending at a reset edge is dropped
      addr_phase(20'h00010, 1'b0);
      we_n = 1'b0; ad_lo = 16'hDEAD; n_rst = 1'b0;
      tick();
      n_rst = 1'b1; we_n = 1'b1;
      tick();
      rd0(20'h00010, 1'b0, 16'hA5A5, "rst wr drop");

      // cycle counter: five accesses, then two counter reads
      do_reset();
      rd0(20'h00003, 1'b1, 16'hB16E, "c1");
      wr0(20'h00000, 1'b1, 16'h1234, "c2");
      rd0(20'h00000, 1'b1, 16'h1234, "c3");
      rd0(20'h00010, 1'b0, 16'hA5A5, "c4");
      rd0(20'h00003, 1'b1, 16'hB16E, "c5");
      rd0(20'h00002, 1'b1, 16'h0005, "cnt5");
      rd0(20'h00002, 1'b1, 16'h0006, "cnt6");

      // three wait states on instance 1
      do_reset();
      addr_phase(20'h00010, 1'b0);
      we_n = 1'b0; ad_lo = 16'hC3C3;
      tick();
      check("ws wr state", st1, S_WAIT);
      check("ws wr rdy1", rdy1, 0);
      tick();
      check("ws wr rdy2", rdy1, 0);
      tick();
      check("ws wr rdy3", rdy1, 0);
      tick();
      check("ws wr rdy4", rdy1, 1);
      check("ws wr oe", ad_oe1, 0);
      check("ws wr active", st1, S_ACTIVE);
      we_n = 1'b1;
      tick();
      check("ws wr rdy off", rdy1, 0);
      rd1(20'h00010, 16'hC3C3, "ws1");

      // strobe released during WAIT: no access
      addr_phase(20'h00010, 1'b0);
      we_n = 1'b0; ad_lo = 16'hDEAD;
      tick();
      check("ws rel wait", st1, S_WAIT);
      we_n = 1'b1;
      tick();
      check("ws rel idle", st1, S_IDLE);
      check("ws rel rdy", rdy1, 0);

      // ale during WAIT aborts the pending write
      addr_phase(20'h00010, 1'b0);
      we_n = 1'b0; ad_lo = 16'hBEEF;
      tick(); tick();
      we_n = 1'b1;
      addr_phase(20'h00020, 1'b0);
      check("ws abort addr", st1, S_ADDR);
      rd1(20'h00010, 16'hC3C3, "ws2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
